gpu_bank_arbiter: RTL
=====================

// Module: gpu_bank_arbiter
// PURPOSE
// - Shares one gpu_bank register-bank port between NUM_WARPS warp read requesters and one writeback port.
// - Issues at most one bank access per cycle: a read or a write.
// - Priority: writes beat reads; reads among warps are round-robin.
// - Drives the bank command lines from registers; tags each read response with warp and register after fixed bank latency.
// PARAMETERS
// - NUM_WARPS  4   warp count; bank_warp_num width = 2
// - REG_W      5   register index width (32 regs); zero-extended onto 64-bit bank reg_num
// - DATA_W     2048 bank row width (32 lanes x 64b)
// - READ_LAT   2   clocks from bank read_bank high to bank out valid
// - STARVE_MAX 4   consecutive write wins tolerated while reads pend (only with macro)
// PORTS
// - clk            in   1                  clock, rising edge
// - rst            in   1                  synchronous reset, active-high
// - rd_req         in   NUM_WARPS          per-warp read request; held until granted
// - rd_reg         in   NUM_WARPS*REG_W    per-warp register index; warp w at [w*REG_W +: REG_W]
// - rd_gnt         out  NUM_WARPS          one-hot grant, combinational; handshake completes at the clock edge
// - wb_valid       in   1                  writeback request
// - wb_warp        in   2                  writeback warp
// - wb_reg         in   REG_W              writeback register
// - wb_data        in   DATA_W             writeback row
// - wb_ready       out  1                  writeback accepted this cycle, combinational
// - bank_read      out  1                  to gpu_bank read_bank, registered
// - bank_write     out  1                  to gpu_bank write_bank, registered
// - bank_reg_num   out  64                 to gpu_bank reg_num, registered
// - bank_warp_num  out  2                  to gpu_bank bank_warp_num, registered
// - bank_wdata     out  DATA_W             to gpu_bank in, registered
// - rsp_valid      out  1                  gpu_bank out holds a granted read's data this cycle
// - rsp_warp       out  2                  warp of the response
// - rsp_reg        out  REG_W              register of the response
// BEHAVIOUR
// - Reset: all outputs 0; rr_ptr=0; starve_cnt=0; response pipeline cleared, so in-flight reads are dropped and never report rsp_valid. Bank contents are not touched.
// - Arbitration per cycle T:
//   - If wb_valid=1, then wb_ready=1 and rd_gnt=0.
//   - Otherwise rd_gnt grants the first requester scanning rr_ptr, rr_ptr+1, ... mod NUM_WARPS.
//   - Grant and ready are never asserted during rst.
// - rr_ptr update: on a read grant to warp w, rr_ptr <= (w+1) mod NUM_WARPS; unchanged otherwise. Wrap from NUM_WARPS-1 to 0.
// - Command: access granted in cycle T appears on the bank_* lines in cycle T+1.
//   - Exactly one of bank_read/bank_write is high; both are 0 in idle cycles.
//   - bank_reg_num = {zeros, reg}.
//   - bank_wdata updates only on write cycles and holds otherwise.
// - Response: a read granted in cycle T gives rsp_valid=1 in cycle T+1+READ_LAT, carrying its warp and register.
//   - Implemented as a READ_LAT+1 deep valid/tag shift register; responses leave in grant order.
//   - Throughput: one response per cycle.
// - Hazards:
//   - Simultaneous write and read of the same warp/reg: write wins; the read is granted later and returns new data.
//   - No read bypass: a read granted in cycle T+1 or later after a write granted in T sees the written data.
// - Idle (no rd_req, no wb_valid): bank_read=bank_write=0; state unchanged.
// CONFIGURATION
// - GPU_BANK_ARB_STARVE_EN defined:
//   - starve_cnt counts consecutive cycles where a write was granted while some rd_req was high.
//   - When starve_cnt==STARVE_MAX and a read pends: the read wins that cycle, wb_ready=0, starve_cnt<=0.
//   - starve_cnt also clears on any read grant or on any cycle with no pending read.
// - GPU_BANK_ARB_STARVE_EN undefined: strict write priority; reads may starve indefinitely; no starve_cnt logic.
// TESTING
// - Reset, then idle 5 cycles -> all outputs 0, no rsp_valid.
// - rd_req=4'b1111 held, reg 3 for all warps -> grants warp 0,1,2,3,0 on consecutive cycles; rsp_valid in the 3rd cycle after the first grant; rsp_warp sequence 0,1,2,3.
// - Write warp 1 reg 7 with row A, then read warp 1 reg 7 -> rsp_valid with warp=1, reg=7 and bank out == A.
// - wb_valid and rd_req[2] together for 3 cycles -> 3 writes, then warp 2 granted in cycle 4. With macro and STARVE_MAX=2, warp 2 is granted in cycle 3 with wb_ready=0.
// - rst asserted for one cycle while 2 reads are in flight -> no rsp_valid afterwards; rr_ptr back to 0, so a 4'b1010 request grants warp 1 first.
// - Only warp 3 requesting, repeatedly -> granted every cycle; rr_ptr wraps 0, next grant still warp 3.

Source files
------------

// File: rtl/gpu_bank_arbiter_if.sv
// gpu_bank_arbiter_if: bundles the warp read-request, writeback, bank command
// and read-response signals of gpu_bank_arbiter.
//   slave  : the arbiter side
//   master : the requester/bank side (warps, writeback unit, gpu_bank, monitor)
interface gpu_bank_arbiter_if #(
   parameter int NUM_WARPS = 4,
   parameter int REG_W     = 5,
   parameter int DATA_W    = 2048
);
   localparam int WARP_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

   // warp read requests
   logic [NUM_WARPS-1:0]       rd_req;
   logic [NUM_WARPS*REG_W-1:0] rd_reg;
   logic [NUM_WARPS-1:0]       rd_gnt;

   // writeback port
   logic                       wb_valid;
   logic [WARP_W-1:0]          wb_warp;
   logic [REG_W-1:0]           wb_reg;
   logic [DATA_W-1:0]          wb_data;
   logic                       wb_ready;

   // gpu_bank command lines
   logic                       bank_read;
   logic                       bank_write;
   logic [63:0]                bank_reg_num;
   logic [WARP_W-1:0]          bank_warp_num;
   logic [DATA_W-1:0]          bank_wdata;

   // read response tag, aligned with gpu_bank output data
   logic                       rsp_valid;
   logic [WARP_W-1:0]          rsp_warp;
   logic [REG_W-1:0]           rsp_reg;

   modport slave (
      input  rd_req, rd_reg, wb_valid, wb_warp, wb_reg, wb_data,
      output rd_gnt, wb_ready,
      output bank_read, bank_write, bank_reg_num, bank_warp_num, bank_wdata,
      output rsp_valid, rsp_warp, rsp_reg
   );

   modport master (
      output rd_req, rd_reg, wb_valid, wb_warp, wb_reg, wb_data,
      input  rd_gnt, wb_ready,
      input  bank_read, bank_write, bank_reg_num, bank_warp_num, bank_wdata,
      input  rsp_valid, rsp_warp, rsp_reg
   );
endinterface

// File: rtl/gpu_bank_arbiter.sv
// gpu_bank_arbiter: shares one gpu_bank port between NUM_WARPS warp readers
// and one writeback port. One access per cycle, writes beat reads, reads are
// round-robin. Bank command lines are registered; each read is tagged with
// its warp/register when the bank output becomes valid READ_LAT clocks later.
// Optional feature: define GPU_BANK_ARB_STARVE_EN to let a pending read win
// after STARVE_MAX consecutive write wins (parameter exists only then).
module gpu_bank_arbiter #(
   parameter int NUM_WARPS  = 4,
   parameter int REG_W      = 5,
   parameter int DATA_W     = 2048,
   parameter int READ_LAT   = 2
`ifdef GPU_BANK_ARB_STARVE_EN
   ,
   parameter int STARVE_MAX = 4
`endif
) (
   input  logic                clk,
   input  logic                rst,
   gpu_bank_arbiter_if.slave   bus
);
   localparam int WARP_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

   // arbitration state and decisions
   logic [WARP_W-1:0] rr_ptr_reg;
   logic [WARP_W-1:0] rr_ptr_next;
   logic              rd_pending;
   logic              rd_sel_found;
   logic [WARP_W-1:0] rd_sel_warp;
   logic [WARP_W-1:0] scan_warp;
   logic [REG_W-1:0]  rd_sel_reg;
   logic              starve_force;
   logic              wr_win;
   logic              rd_win;

   // registered bank command
   logic              bank_read_reg;
   logic              bank_write_reg;
   logic [63:0]       bank_reg_num_reg;
   logic [WARP_W-1:0] bank_warp_num_reg;
   logic [DATA_W-1:0] bank_wdata_reg;

   // response tag pipeline, stage READ_LAT lines up with bank output data
   logic              rsp_v_reg [READ_LAT+1];
   logic [WARP_W-1:0] rsp_w_reg [READ_LAT+1];
   logic [REG_W-1:0]  rsp_r_reg [READ_LAT+1];

   // per-warp register index slices
   logic [REG_W-1:0]  warp_reg [NUM_WARPS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
         assign warp_reg[gi]   = bus.rd_reg[gi*REG_W +: REG_W];
         assign bus.rd_gnt[gi] = rd_win && (rd_sel_warp == WARP_W'(gi));
      end
   endgenerate

   assign rd_pending = |bus.rd_req;

   // round-robin scan starting at rr_ptr: first requesting warp wins
   always_comb begin
      rd_sel_found = 1'b0;
      rd_sel_warp  = '0;
      scan_warp    = '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         scan_warp = WARP_W'((int'(rr_ptr_reg) + i) % NUM_WARPS);
         if (!rd_sel_found && bus.rd_req[scan_warp]) begin
            rd_sel_found = 1'b1;
            rd_sel_warp  = scan_warp;
         end
      end
   end

   assign rd_sel_reg  = warp_reg[rd_sel_warp];
   assign rr_ptr_next = (rd_sel_warp == WARP_W'(NUM_WARPS - 1)) ? '0
                                                                 : rd_sel_warp + 1'b1;

`ifdef GPU_BANK_ARB_STARVE_EN
   localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   logic [CNT_W-1:0] starve_cnt_reg;
   logic [CNT_W-1:0] starve_cnt_next;

   // a pending read that has lost STARVE_MAX times in a row takes this cycle
   assign starve_force = rd_pending && (starve_cnt_reg == CNT_W'(STARVE_MAX));

   // count consecutive write wins that left a read waiting
   always_comb begin
      starve_cnt_next = starve_cnt_reg;
      if (!rd_pending || rd_win) begin
         starve_cnt_next = '0;
      end else if (wr_win && (starve_cnt_reg != CNT_W'(STARVE_MAX))) begin
         starve_cnt_next = starve_cnt_reg + 1'b1;
      end
   end

   // starvation counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_reg <= '0;
      end else begin
         starve_cnt_reg <= starve_cnt_next;
      end
   end
`else
   assign starve_force = 1'b0;
`endif

   // write has priority unless a starving read is forced through; nothing
   // is granted while reset is held
   assign wr_win       = !rst && bus.wb_valid && !starve_force;
   assign rd_win       = !rst && rd_sel_found && !wr_win;
   assign bus.wb_ready = wr_win;

   // round-robin pointer advances past the warp just granted
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_reg <= '0;
      end else if (rd_win) begin
         rr_ptr_reg <= rr_ptr_next;
      end
   end

   // register the winning access onto the bank command lines; address and
   // data hold their last value in idle cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_read_reg     <= 1'b0;
         bank_write_reg    <= 1'b0;
         bank_reg_num_reg  <= '0;
         bank_warp_num_reg <= '0;
         bank_wdata_reg    <= '0;
      end else begin
         bank_read_reg  <= rd_win;
         bank_write_reg <= wr_win;
         if (wr_win) begin
            bank_warp_num_reg <= bus.wb_warp;
            bank_reg_num_reg  <= 64'(bus.wb_reg);
            bank_wdata_reg    <= bus.wb_data;
         end else if (rd_win) begin
            bank_warp_num_reg <= rd_sel_warp;
            bank_reg_num_reg  <= 64'(rd_sel_reg);
         end
      end
   end

   assign bus.bank_read     = bank_read_reg;
   assign bus.bank_write    = bank_write_reg;
   assign bus.bank_reg_num  = bank_reg_num_reg;
   assign bus.bank_warp_num = bank_warp_num_reg;
   assign bus.bank_wdata    = bank_wdata_reg;

   generate
      for (gi = 0; gi <= READ_LAT; gi++) begin : g_rsp
         if (gi == 0) begin : g_head
            // capture the tag of the read granted this cycle
            always_ff @(posedge clk) begin
               if (rst) begin
                  rsp_v_reg[gi] <= 1'b0;
                  rsp_w_reg[gi] <= '0;
                  rsp_r_reg[gi] <= '0;
               end else begin
                  rsp_v_reg[gi] <= rd_win;
                  rsp_w_reg[gi] <= rd_win ? rd_sel_warp : '0;
                  rsp_r_reg[gi] <= rd_win ? rd_sel_reg  : '0;
               end
            end
         end else begin : g_body
            // shift the tag along with the bank read latency
            always_ff @(posedge clk) begin
               if (rst) begin
                  rsp_v_reg[gi] <= 1'b0;
                  rsp_w_reg[gi] <= '0;
                  rsp_r_reg[gi] <= '0;
               end else begin
                  rsp_v_reg[gi] <= rsp_v_reg[gi-1];
                  rsp_w_reg[gi] <= rsp_w_reg[gi-1];
                  rsp_r_reg[gi] <= rsp_r_reg[gi-1];
               end
            end
         end
      end
   endgenerate

   assign bus.rsp_valid = rsp_v_reg[READ_LAT];
   assign bus.rsp_warp  = rsp_w_reg[READ_LAT];
   assign bus.rsp_reg   = rsp_r_reg[READ_LAT];

endmodule
